// File: rtl/exec_pkg.sv
// Shared constants for the EX stage: ALU opcodes, forwarding selects and flag bit positions.
package exec_pkg;
  localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_ASR = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12, OP_PASS = 4'd13, OP_INC = 4'd14, OP_DEC = 4'd15;

  localparam logic [1:0] FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_DM = 2'b10, FWD_WB = 2'b11;

  // flags_ex is packed {Z,N,C,V}
  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
endpackage

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU: one shared adder serves all add/subtract ops, with result, carry and overflow.
module alu_core
  import exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);
  localparam int M = WIDTH - 1;

  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic             arith;
  logic [WIDTH:0]   sum;

  // Subtracts are a + ~b + cin, so C=1 means no borrow.
  always_comb begin
    add_b  = b;
    add_ci = 1'b0;
    arith  = 1'b1;
    case (op)
      OP_ADD: ;
      OP_ADC: add_ci = cin;
      OP_SUB: begin add_b = ~b; add_ci = 1'b1; end
      OP_SBB: begin add_b = ~b; add_ci = cin;  end
      OP_INC: add_b = WIDTH'(1);
      OP_DEC: begin add_b = ~WIDTH'(1); add_ci = 1'b1; end
      default: arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

  always_comb begin
    result = sum[M:0];
    c      = 1'b0;
    v      = 1'b0;
    if (arith) begin
      c = sum[WIDTH];
      v = (a[M] == add_b[M]) && (sum[M] != a[M]);
    end else begin
      case (op)
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_NOT:  result = ~a;
        OP_SHL:  begin result = {a[M-1:0], 1'b0}; c = a[M]; end
        OP_SHR:  begin result = {1'b0, a[M:1]};   c = a[0]; end
        OP_ASR:  begin result = {a[M], a[M:1]};   c = a[0]; end
        OP_ROL:  begin result = {a[M-1:0], a[M]}; c = a[M]; end
        OP_ROR:  begin result = {a[0], a[M:1]};   c = a[0]; end
        default: result = b;
      endcase
    end
  end
endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: operand forwarding, ALU, flag register and EX/DM pipeline registers.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             imm_sel_in,
  input  logic [OP_W-1:0]  alu_op_in,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] ans_dm,
  input  logic [WIDTH-1:0] ans_wb,
  input  logic             mem_rw_in,
  input  logic             mem_en_in,
  input  logic             mem_mux_sel_in,
  input  logic             flag_en_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] DM_data,
  output logic             mem_rw_ex,
  output logic             mem_en_ex,
  output logic             mem_mux_sel_dm,
  output logic [3:0]       flags_ex
);
  logic [WIDTH-1:0] opa, opb, alu_b, alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       flags_nxt;

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel, input logic [WIDTH-1:0] rf,
                                               input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] dm,
                                               input logic [WIDTH-1:0] wb);
    case (sel)
      FWD_EX:  return ex;
      FWD_DM:  return dm;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  assign opa   = fwd_mux(fwd_a_sel, a_in, ans_ex, ans_dm, ans_wb);
  assign opb   = fwd_mux(fwd_b_sel, b_in, ans_ex, ans_dm, ans_wb);
  assign alu_b = imm_sel_in ? imm_in : opb;

  alu_core #(.WIDTH(WIDTH), .OP_W(OP_W)) u_alu (
    .a(opa), .b(alu_b), .cin(flags_ex[F_C]), .op(alu_op_in),
    .result(alu_res), .c(alu_c), .v(alu_v)
  );

  always_comb begin
    flags_nxt      = '0;
    flags_nxt[F_Z] = (alu_res == '0);
    flags_nxt[F_N] = alu_res[WIDTH-1];
    flags_nxt[F_C] = alu_c;
    flags_nxt[F_V] = alu_v;
  end

  // Flush beats stall; flags are never cleared by a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_ex         <= '0;
      DM_data        <= '0;
      mem_rw_ex      <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_mux_sel_dm <= 1'b0;
      flags_ex       <= '0;
    end else if (flush) begin
      ans_ex         <= '0;
      DM_data        <= '0;
      mem_rw_ex      <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_mux_sel_dm <= 1'b0;
    end else if (!stall) begin
      ans_ex         <= alu_res;
      DM_data        <= opb;
      mem_rw_ex      <= mem_rw_in;
      mem_en_ex      <= mem_en_in;
      mem_mux_sel_dm <= mem_mux_sel_in;
      if (flag_en_in) flags_ex <= flags_nxt;
    end
  end
endmodule
